// File: rtl/id_hazard_pc_ctrl_pkg.sv
// Shared definitions for the ID-stage hazard / PC control slice:
// opcode constants, PC-source encoding, instruction classes and FSM states.
package id_hazard_pc_ctrl_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;
  localparam logic [5:0] FN_JR      = 6'b001000;

  typedef enum logic [2:0] {
    PCSRC_PC4     = 3'd0,
    PCSRC_SUMIMM  = 3'd1,
    PCSRC_SEIMM26 = 3'd2,
    PCSRC_RREG1   = 3'd3,
    PCSRC_IDPC4   = 3'd4
  } pcsrc_e;

  typedef enum logic [2:0] {
    IC_OTHER = 3'd0,
    IC_BR1   = 3'd1,
    IC_BR2   = 3'd2,
    IC_J     = 3'd3,
    IC_JR    = 3'd4
  } instr_class_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  function automatic instr_class_e classify(input logic [5:0] op, input logic [5:0] funct);
    instr_class_e c;
    c = IC_OTHER;
    case (op)
      OP_BEQ, OP_BNE:               c = IC_BR2;
      OP_REGIMM, OP_BLEZ, OP_BGTZ:  c = IC_BR1;
      OP_J, OP_JAL:                 c = IC_J;
      OP_SPECIAL:                   if (funct == FN_JR) c = IC_JR;
      default:                      c = IC_OTHER;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_hazard_detect.sv
// Combinational decode of the IF/ID instruction and stall-length (0..2)
// computation from the ID/EX and EX/MEM destination registers.
module id_hazard_detect
  import id_hazard_pc_ctrl_pkg::*;
(
  input  logic [31:0]   i_instr,
  input  logic          i_idex_reg_write,
  input  logic          i_idex_mem_read,
  input  logic [4:0]    i_idex_rd,
  input  logic          i_exmem_mem_read,
  input  logic [4:0]    i_exmem_rd,
  output instr_class_e  o_class,
  output logic [1:0]    o_stall_len
);

  logic [4:0]   w_rs;
  logic [4:0]   w_rt;
  logic         w_use_rs;
  logic         w_use_rt;
  logic         w_is_ctrl;
  logic         w_idex_hit;
  logic         w_exmem_hit;
  logic         w_unused_bits;
  instr_class_e w_class;

  assign w_rs          = i_instr[25:21];
  assign w_rt          = i_instr[20:16];
  assign w_unused_bits = ^i_instr[15:6];
  assign w_class       = classify(i_instr[31:26], i_instr[5:0]);

  assign w_use_rs  = (w_class != IC_J);
  assign w_use_rt  = (w_class == IC_BR2) || (w_class == IC_OTHER);
  assign w_is_ctrl = (w_class == IC_BR1) || (w_class == IC_BR2) || (w_class == IC_JR);

  // r0 is hardwired zero, so a producer targeting it never creates a dependency.
  assign w_idex_hit  = (i_idex_rd != 5'd0) &&
                       ((w_use_rs && (w_rs == i_idex_rd)) || (w_use_rt && (w_rt == i_idex_rd)));
  assign w_exmem_hit = (i_exmem_rd != 5'd0) &&
                       ((w_use_rs && (w_rs == i_exmem_rd)) || (w_use_rt && (w_rt == i_exmem_rd)));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    o_stall_len = 2'd0;
    if (i_idex_mem_read && w_idex_hit)
      o_stall_len = 2'd1;
    if (w_is_ctrl) begin
      if (i_idex_reg_write && !i_idex_mem_read && w_idex_hit)
        o_stall_len = 2'd1;
      if (i_exmem_mem_read && w_exmem_hit)
        o_stall_len = 2'd1;
      // Compare in ID needs the loaded value, which is two cycles away.
      if (i_idex_mem_read && w_idex_hit)
        o_stall_len = 2'd2;
    end
  end

  assign o_class = w_class;

endmodule

// File: rtl/id_hazard_pc_ctrl.sv
// ID-stage control: stall FSM, branch/jump resolution driving the IF-stage
// controls, and saturating mispredict / stall counters.
module id_hazard_pc_ctrl
  import id_hazard_pc_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [31:0]      IFIDInstr,
  input  logic             IFIDCache,
  input  logic             BranchTaken,
  input  logic             IDEXRegWrite,
  input  logic             IDEXMemRead,
  input  logic [4:0]       IDEXRd,
  input  logic             EXMEMMemRead,
  input  logic [4:0]       EXMEMRd,
  output logic             cPCWrite,
  output logic             cWrite,
  output logic             cFlush,
  output logic [2:0]       cPCSrc,
  output logic             cIDEXBubble,
  output logic [CNT_W-1:0] oMispredict,
  output logic [CNT_W-1:0] oStallCnt
);

  state_e           r_state;
  state_e           w_next_state;
  logic [1:0]       r_cnt;
  logic [1:0]       w_next_cnt;
  logic [CNT_W-1:0] r_mispredict;
  logic [CNT_W-1:0] r_stall_cnt;

  instr_class_e     w_class;
  logic [1:0]       w_stall_len;

  logic             w_pc_write;
  logic             w_write;
  logic             w_flush;
  pcsrc_e           w_pcsrc;
  logic             w_bubble;

  id_hazard_detect u_detect (
    .i_instr          (IFIDInstr),
    .i_idex_reg_write (IDEXRegWrite),
    .i_idex_mem_read  (IDEXMemRead),
    .i_idex_rd        (IDEXRd),
    .i_exmem_mem_read (EXMEMMemRead),
    .i_exmem_rd       (EXMEMRd),
    .o_class          (w_class),
    .o_stall_len      (w_stall_len)
  );

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_pc_write   = 1'b0;
    w_write      = 1'b0;
    w_flush      = 1'b0;
    w_pcsrc      = PCSRC_PC4;
    w_bubble     = 1'b1;
    case (r_state)
      ST_RUN: begin
        if (w_stall_len == 2'd2) begin
          // r_cnt = bubbles still owed after this one.
          w_next_state = ST_STALL;
          w_next_cnt   = 2'd1;
        end else if (w_stall_len == 2'd0) begin
          w_pc_write = 1'b1;
          w_write    = 1'b1;
          w_bubble   = 1'b0;
          case (w_class)
            IC_BR1, IC_BR2: begin
              if (BranchTaken && !IFIDCache) begin
                w_pcsrc = PCSRC_SUMIMM;
                w_flush = 1'b1;
              end else if (!BranchTaken && IFIDCache) begin
                w_pcsrc = PCSRC_IDPC4;
                w_flush = 1'b1;
              end
            end
            IC_J: begin
              if (!IFIDCache) begin
                w_pcsrc = PCSRC_SEIMM26;
                w_flush = 1'b1;
              end
            end
            IC_JR: begin
              w_pcsrc = PCSRC_RREG1;
              w_flush = 1'b1;
            end
            default: begin
              // Branch-cache alias on a non-control instr: refetch its fall-through.
              if (IFIDCache) begin
                w_pcsrc = PCSRC_IDPC4;
                w_flush = 1'b1;
              end
            end
          endcase
        end
      end
      ST_STALL: begin
        if (r_cnt <= 2'd1) begin
          w_next_state = ST_RUN;
          w_next_cnt   = 2'd0;
        end else begin
          w_next_cnt = r_cnt - 2'd1;
        end
      end
      default: begin
        w_next_state = ST_RUN;
        w_next_cnt   = 2'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state      <= ST_RUN;
      r_cnt        <= 2'd0;
      r_mispredict <= '0;
      r_stall_cnt  <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (w_flush && (r_mispredict != {CNT_W{1'b1}}))
        r_mispredict <= r_mispredict + 1'b1;
      if (w_bubble && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  // While reset is held the IF stage is frozen and IF/ID is loaded with a NOP.
  assign cPCWrite    = Reset ? w_pc_write : 1'b0;
  assign cWrite      = Reset ? w_write    : 1'b0;
  assign cFlush      = Reset ? w_flush    : 1'b1;
  assign cPCSrc      = Reset ? w_pcsrc    : PCSRC_PC4;
  assign cIDEXBubble = Reset ? w_bubble   : 1'b1;
  assign oMispredict = r_mispredict;
  assign oStallCnt   = r_stall_cnt;

endmodule
